kbd_matrix_debounce: RTL
========================

KBD_MATRIX_DEBOUNCE -- requirements
Module: kbd_matrix_debounce

Interface
REQ-001 The block SHALL expose parameter DIV, default 256: number of clk cycles per debounce sample tick (range 2..65536).
REQ-002 The block SHALL expose parameter DEB, default 4: number of consecutive disagreeing ticks required to flip a debounced key (range 1..7).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, posedge; it is the same clock that drives the CPU core.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port ena, input, 1 bit: when 0, all registers hold their values.
REQ-006 The block SHALL have port key_raw, input, 16 bits: asynchronous switch states, 1 = pressed, key index = 4*column + row.
REQ-007 The block SHALL have port nL, input, 4 bits: active-low column strobes from the CPU Lreg.
REQ-008 The block SHALL have port KIN, output, 4 bits: row data to the CPU KIN input, 1 = pressed.
REQ-009 The block SHALL have port key_code, output, 4 bits: index of the latched press event.
REQ-010 The block SHALL have port key_valid, output, 1 bit: high while key_code holds an unacknowledged event.
REQ-011 The block SHALL have port key_ack, input, 1 bit: one-cycle pulse that clears key_valid.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky flag for a lost press event.

Function
REQ-013 key_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 A prescaler SHALL count 0..DIV-1, wrapping to 0; tick is asserted for one cycle when the count equals DIV-1.
REQ-015 Each key SHALL have a 3-bit counter and a debounced state bit; all logic in REQ-015 to REQ-017 SHALL update only on tick.
REQ-016 On tick, when the synchronized raw value equals the debounced value, that key's counter SHALL reset to 0.
REQ-017 On tick, when the values differ, the counter SHALL increment; on reaching DEB, the debounced bit SHALL toggle and the counter SHALL reset to 0.
REQ-018 KIN[r] SHALL be the combinational OR of debounced[4c+r] over every column c with nL[c]==0.
REQ-019 KIN SHALL be 4'b0000 when nL==4'b1111.
REQ-020 A press event is a debounced 0->1 transition; events SHALL be evaluated in the same cycle that the debounced bit updates.
REQ-021 If key_valid==0, or key_ack==1 in that cycle, the lowest-index new press SHALL load key_code and set key_valid=1; the new press has priority over ack.
REQ-022 Additional new presses in the same tick, or any press while key_valid==1 without a concurrent ack, SHALL set overrun=1 and be dropped.
REQ-023 key_ack with no event pending SHALL clear key_valid the following cycle and have no effect on overrun.
REQ-024 overrun SHALL clear only on rst.
REQ-025 Releases (1->0) SHALL generate no event.
REQ-026 Latency from a stable raw change to the debounced flip SHALL be at most 2 + DIV*DEB clk cycles and at least 2 + DIV*(DEB-1) + 1.
REQ-027 A raw glitch shorter than DEB consecutive ticks SHALL leave the debounced state unchanged.

Reset
REQ-028 On rst=1 at a clk edge, the synchronizer, prescaler, all counters, all debounced bits, key_code, key_valid and overrun SHALL become 0.
REQ-029 rst SHALL override ena.
REQ-030 After reset, the first tick SHALL occur DIV cycles after rst deasserts.
REQ-031 Reset asserted mid-debounce SHALL discard the partial count, and no event SHALL be produced.

Verification (DIV=4, DEB=3)
REQ-032 Scenario: hold key_raw[5]=1 from cycle 0 -> debounced[5] set after the 3rd tick; key_valid=1 with key_code=5; nL=4'b1101 gives KIN=4'b0010.
REQ-033 Scenario: pulse key_raw[2]=1 for 6 cycles only -> no debounced change, key_valid stays 0, KIN stays 0.
REQ-034 Scenario: keys 3 and 9 become stable in the same cycle -> key_code=3, key_valid=1, overrun=1.
REQ-035 Scenario: key 7 pending and key 12 flips in the same cycle as key_ack -> key_code=12, key_valid=1, overrun=0.
REQ-036 Scenario: nL=4'b0000 with keys 0 and 13 debounced -> KIN=4'b0011.
REQ-037 Scenario: ena=0 for 20 cycles mid-count, then rst pulse -> state frozen while ena=0; all outputs 0 after reset; first tick 4 cycles later.

Source files
------------

// File: rtl/kbd_matrix_debounce.sv
// 4x4 key matrix scanner: synchronizes raw switches, debounces each key on a prescaled tick, latches press events.
// Latency: 2 sync cycles plus DEB ticks to flip a key; key_valid holds until key_ack; presses arriving while it is held are dropped and set overrun.
module kbd_matrix_debounce #(
   parameter int DIV = 256,
   parameter int DEB = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic [15:0] key_raw,
   input  logic [3:0]  nL,
   output logic [3:0]  KIN,
   output logic [3:0]  key_code,
   output logic        key_valid,
   input  logic        key_ack,
   output logic        overrun
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
   localparam logic [2:0]    DEB_MAX = 3'(DEB - 1);

   logic [15:0]   sync1;
   logic [15:0]   sync2;
   logic [PW-1:0] pre_cnt;
   logic          tick;
   logic          upd;
   logic [2:0]    deb_cnt [16];
   logic [15:0]   deb;
   logic [15:0]   flip;
   logic [15:0]   press;
   logic [3:0]    first_idx;
   logic          multi;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else if (ena) begin
         sync1 <= key_raw;
         sync2 <= sync1;
      end
   end

   assign tick = (pre_cnt == PRE_MAX);
   assign upd  = ena & tick;

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt <= '0;
      end else if (ena) begin
         pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      end
   end

   // A key flips on the tick where its disagreement count would reach DEB.
   always_comb begin
      flip = '0;
      for (int k = 0; k < 16; k++) begin
         flip[k] = upd && (sync2[k] != deb[k]) && (deb_cnt[k] == DEB_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         deb <= '0;
         for (int k = 0; k < 16; k++) begin
            deb_cnt[k] <= '0;
         end
      end else if (upd) begin
         deb <= deb ^ flip;
         for (int k = 0; k < 16; k++) begin
            if (sync2[k] == deb[k] || flip[k]) begin
               deb_cnt[k] <= '0;
            end else begin
               deb_cnt[k] <= deb_cnt[k] + 3'd1;
            end
         end
      end
   end

   assign press = flip & ~deb;
   assign multi = |(press & (press - 16'd1));

   always_comb begin
      first_idx = '0;
      for (int k = 15; k >= 0; k--) begin
         if (press[k]) begin
            first_idx = 4'(k);
         end
      end
   end

   // A new press wins over a concurrent ack; everything that cannot be latched counts as lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_code  <= '0;
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (ena) begin
         if (|press) begin
            if (!key_valid || key_ack) begin
               key_code  <= first_idx;
               key_valid <= 1'b1;
               if (multi) begin
                  overrun <= 1'b1;
               end
            end else begin
               overrun <= 1'b1;
            end
         end else if (key_ack) begin
            key_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      KIN = '0;
      for (int c = 0; c < 4; c++) begin
         if (!nL[c]) begin
            KIN = KIN | deb[4*c +: 4];
         end
      end
   end

endmodule
